// File: rtl/fft_peak_pkg.sv
// Shared types and helpers for the FFT peak search block.
package fft_peak_pkg;

  localparam int DATA_W = 32;
  localparam int POS_W  = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEARCH     = 2'd1,
    WAIT_RIGHT = 2'd2
  } state_e;

  // Magnitude key of a float32 power value: negative values collapse to 0,
  // otherwise exponent+mantissa compare correctly as an unsigned integer
  // (Inf/NaN land above every finite value).
  function automatic logic [30:0] float_key(input logic [31:0] f);
    return f[31] ? 31'd0 : f[30:0];
  endfunction

endpackage

// File: rtl/float_mag_gt.sv
// Combinational strict greater-than on float32 magnitude keys.
module float_mag_gt
  import fft_peak_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        gt_o
);

  // Strict compare keeps the first occurrence on ties.
  always_comb gt_o = float_key(a_i) > float_key(b_i);

endmodule

// File: rtl/fft_peak_search.sv
// Per-frame maximum bin tracker with left/right neighbour capture.
// Optional threshold compare is enabled by defining PEAK_THRESHOLD_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | no sample accepted yet in the current frame
// WAIT_RIGHT | current max has no right neighbour yet
// SEARCH     | max and both neighbours known; only a larger value moves it
module fft_peak_search
  import fft_peak_pkg::*;
#(
  parameter int DATA_W = fft_peak_pkg::DATA_W,
  parameter int POS_W  = fft_peak_pkg::POS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_en,
  input  logic [POS_W-1:0]  s_position,
  input  logic              frame_end,
`ifdef PEAK_THRESHOLD_EN
  input  logic [DATA_W-1:0] peak_threshold,
  output logic              peak_found,
`endif
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_value,
  output logic [DATA_W-1:0] peak_left,
  output logic [DATA_W-1:0] peak_right,
  output logic [POS_W-1:0]  peak_position,
  output logic              peak_edge,
  output logic              peak_empty,
  output logic [POS_W:0]    sample_count
);

  localparam logic [POS_W:0] CNT_MAX = {1'b1, {POS_W{1'b0}}};

  state_e             state_q, state_d, nx_state;
  logic [DATA_W-1:0]  max_val_q, max_val_d, nx_max_val;
  logic [POS_W-1:0]   max_pos_q, max_pos_d, nx_max_pos;
  logic [DATA_W-1:0]  left_val_q, left_val_d, nx_left_val;
  logic [DATA_W-1:0]  right_val_q, right_val_d, nx_right_val;
  logic [DATA_W-1:0]  prev_val_q, prev_val_d, nx_prev_val;
  logic               left_miss_q, left_miss_d, nx_left_miss;
  logic [POS_W:0]     cnt_q, cnt_d, nx_cnt;

  logic               pk_valid_q, pk_valid_d;
  logic [DATA_W-1:0]  pk_value_q, pk_value_d;
  logic [DATA_W-1:0]  pk_left_q, pk_left_d;
  logic [DATA_W-1:0]  pk_right_q, pk_right_d;
  logic [POS_W-1:0]   pk_pos_q, pk_pos_d;
  logic               pk_edge_q, pk_edge_d;
  logic               pk_empty_q, pk_empty_d;
  logic [POS_W:0]     pk_cnt_q, pk_cnt_d;

  logic               new_max;
  logic               thr_gt;

  float_mag_gt u_max_gt (
    .a_i  (s_data),
    .b_i  (max_val_q),
    .gt_o (new_max)
  );

`ifdef PEAK_THRESHOLD_EN
  logic pk_found_q, pk_found_d;

  // Threshold is judged against the peak including any same-cycle sample.
  float_mag_gt u_thr_gt (
    .a_i  (nx_max_val),
    .b_i  (peak_threshold),
    .gt_o (thr_gt)
  );
`else
  assign thr_gt = 1'b0;
`endif

  // Frame tracking: fold the current sample (if any) into the running peak.
  always_comb begin
    nx_state     = state_q;
    nx_max_val   = max_val_q;
    nx_max_pos   = max_pos_q;
    nx_left_val  = left_val_q;
    nx_right_val = right_val_q;
    nx_prev_val  = prev_val_q;
    nx_left_miss = left_miss_q;
    nx_cnt       = cnt_q;
    if (s_en) begin
      nx_prev_val = s_data;
      if (cnt_q != CNT_MAX) nx_cnt = cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          nx_max_val   = s_data;
          nx_max_pos   = s_position;
          nx_left_val  = '0;
          nx_right_val = '0;
          nx_left_miss = 1'b1;
          nx_state     = WAIT_RIGHT;
        end
        WAIT_RIGHT: begin
          if (new_max) begin
            nx_max_val   = s_data;
            nx_max_pos   = s_position;
            nx_left_val  = prev_val_q;
            nx_left_miss = 1'b0;
          end else begin
            nx_right_val = s_data;
            nx_state     = SEARCH;
          end
        end
        SEARCH: begin
          if (new_max) begin
            nx_max_val   = s_data;
            nx_max_pos   = s_position;
            nx_left_val  = prev_val_q;
            nx_right_val = '0;
            nx_left_miss = 1'b0;
            nx_state     = WAIT_RIGHT;
          end
        end
        default: nx_state = IDLE;
      endcase
    end
  end

  // Register next-state: a frame end publishes the result and restarts tracking.
  always_comb begin
    state_d     = nx_state;
    max_val_d   = nx_max_val;
    max_pos_d   = nx_max_pos;
    left_val_d  = nx_left_val;
    right_val_d = nx_right_val;
    prev_val_d  = nx_prev_val;
    left_miss_d = nx_left_miss;
    cnt_d       = nx_cnt;
    pk_valid_d  = 1'b0;
    pk_value_d  = pk_value_q;
    pk_left_d   = pk_left_q;
    pk_right_d  = pk_right_q;
    pk_pos_d    = pk_pos_q;
    pk_edge_d   = pk_edge_q;
    pk_empty_d  = pk_empty_q;
    pk_cnt_d    = pk_cnt_q;
`ifdef PEAK_THRESHOLD_EN
    pk_found_d  = pk_found_q;
`endif
    if (frame_end) begin
      pk_valid_d = 1'b1;
      pk_cnt_d   = nx_cnt;
      if (nx_state == IDLE) begin
        pk_empty_d = 1'b1;
        pk_value_d = '0;
        pk_left_d  = '0;
        pk_right_d = '0;
        pk_pos_d   = '0;
        pk_edge_d  = 1'b0;
`ifdef PEAK_THRESHOLD_EN
        pk_found_d = 1'b0;
`endif
      end else begin
        pk_empty_d = 1'b0;
        pk_value_d = nx_max_val;
        pk_left_d  = nx_left_miss ? '0 : nx_left_val;
        pk_right_d = (nx_state == WAIT_RIGHT) ? '0 : nx_right_val;
        pk_pos_d   = nx_max_pos;
        pk_edge_d  = nx_left_miss || (nx_state == WAIT_RIGHT);
`ifdef PEAK_THRESHOLD_EN
        pk_found_d = thr_gt;
`endif
      end
      state_d     = IDLE;
      max_val_d   = '0;
      max_pos_d   = '0;
      left_val_d  = '0;
      right_val_d = '0;
      prev_val_d  = '0;
      left_miss_d = 1'b0;
      cnt_d       = '0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      max_val_q   <= '0;
      max_pos_q   <= '0;
      left_val_q  <= '0;
      right_val_q <= '0;
      prev_val_q  <= '0;
      left_miss_q <= 1'b0;
      cnt_q       <= '0;
      pk_valid_q  <= 1'b0;
      pk_value_q  <= '0;
      pk_left_q   <= '0;
      pk_right_q  <= '0;
      pk_pos_q    <= '0;
      pk_edge_q   <= 1'b0;
      pk_empty_q  <= 1'b0;
      pk_cnt_q    <= '0;
`ifdef PEAK_THRESHOLD_EN
      pk_found_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      max_val_q   <= max_val_d;
      max_pos_q   <= max_pos_d;
      left_val_q  <= left_val_d;
      right_val_q <= right_val_d;
      prev_val_q  <= prev_val_d;
      left_miss_q <= left_miss_d;
      cnt_q       <= cnt_d;
      pk_valid_q  <= pk_valid_d;
      pk_value_q  <= pk_value_d;
      pk_left_q   <= pk_left_d;
      pk_right_q  <= pk_right_d;
      pk_pos_q    <= pk_pos_d;
      pk_edge_q   <= pk_edge_d;
      pk_empty_q  <= pk_empty_d;
      pk_cnt_q    <= pk_cnt_d;
`ifdef PEAK_THRESHOLD_EN
      pk_found_q  <= pk_found_d;
`endif
    end
  end

  assign peak_valid    = pk_valid_q;
  assign peak_value    = pk_value_q;
  assign peak_left     = pk_left_q;
  assign peak_right    = pk_right_q;
  assign peak_position = pk_pos_q;
  assign peak_edge     = pk_edge_q;
  assign peak_empty    = pk_empty_q;
  assign sample_count  = pk_cnt_q;
`ifdef PEAK_THRESHOLD_EN
  assign peak_found    = pk_found_q;
`else
  logic unused_thr;
  assign unused_thr = thr_gt;
`endif

endmodule

// File: doc/fft_peak_search.md
# fft_peak_search

Downstream of the spectral window selector. Consumes the gated stream of float32 |X|² values with their bin positions, tracks the maximum bin within each frame, and captures its left and right neighbours for later three-point interpolation. It reports one result record per frame, one cycle after the frame-end strobe.

## Interface
- DATA_W, 32, float32 word width
- POS_W, 8, bin position width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high; clears all state and outputs
- s_data  in  DATA_W  |X|² sample, IEEE-754 single precision
- s_en  in  1  sample valid, one sample per asserted cycle, no backpressure
- s_position  in  POS_W  bin index of s_data
- frame_end  in  1  single-cycle frame terminator; a sample with s_en in the same cycle belongs to the ending frame
- peak_valid  out  1  one-cycle result strobe, reset 0
- peak_value  out  DATA_W  maximum sample, reset 0
- peak_left  out  DATA_W  sample preceding the peak, reset 0
- peak_right  out  DATA_W  sample following the peak, reset 0
- peak_position  out  POS_W  s_position of the peak, reset 0
- peak_edge  out  1  peak was the first or last sample of the frame, so a neighbour is missing; reset 0
- peak_empty  out  1  frame had no samples, reset 0
- sample_count  out  POS_W+1  samples received in the reported frame, reset 0

## Operation
- Compare rule: the key is s_data[30:0] compared as unsigned. A set sign bit forces the key to 0. Inf and NaN compare as the largest keys. The strict greater-than rule means the first occurrence wins on ties.
- Internal registers: max_val, max_pos, left_val, right_val, prev_val (last accepted sample), left_miss, cnt.
- FSM states:
  - IDLE: no sample yet in the frame. On s_en, the sample becomes the max, left_miss=1, left_val=0, and the state moves to WAIT_RIGHT.
  - WAIT_RIGHT: the max has no right neighbour yet. On s_en:
    - if greater, the sample becomes the new max, left_val=prev_val, left_miss=0, and the state stays in WAIT_RIGHT;
    - otherwise right_val=sample and the state moves to SEARCH.
  - SEARCH: the max is complete. On s_en:
    - if greater, the sample becomes the new max, left_val=prev_val, left_miss=0, and the state moves to WAIT_RIGHT;
    - otherwise there is no change.
- prev_val and cnt update on every s_en. cnt saturates at 2^POS_W.
- frame_end at cycle T:
  - The next-state values, including any same-cycle sample, load the output registers at edge T+1.
  - peak_edge = left_miss OR (next state is WAIT_RIGHT). A missing right neighbour reads as 0.
  - peak_empty=1 when the next state is IDLE. In that case peak_value, peak_left, peak_right and peak_position are 0.
  - The FSM returns to IDLE, and cnt, left/right, prev and max clear.
- Samples arriving at T+1 or later start the next frame. There is no dead cycle.
- Output registers hold their values between strobes.
- Asserting rst mid-frame discards the partial frame. No strobe is issued for it.

## Timing
- Result latency: peak_valid is high for exactly one cycle, at T+1 after frame_end.
- Throughput: one sample per cycle. Back-to-back frame_end strobes each produce a strobe.
- Internal state has no pipeline stages. Comparison and update complete in one cycle.

## Configuration
- PEAK_THRESHOLD_EN, when defined:
  - adds input peak_threshold [DATA_W-1:0], same key rule, sampled on frame_end;
  - adds output peak_found, reset 0. It is 1 if the peak key is strictly above the threshold, else 0 (and 0 on an empty frame).
- When PEAK_THRESHOLD_EN is undefined, neither port exists and behaviour is otherwise identical.

## Structure
- Package fft_peak_pkg holds:
  - the DATA_W/POS_W defaults;
  - the FSM state enum {IDLE, SEARCH, WAIT_RIGHT};
  - the float key function (sign-clamp, [30:0] extract).
- Sub-module float_mag_gt: combinational a>b on float keys, instanced for the max compare and, under PEAK_THRESHOLD_EN, for the threshold compare.

## Test plan
- Frame values 1.0, 3.0, 2.0, 0.5 at positions 10..13, frame_end with the last sample:
  - peak_value=3.0 (0x40400000), left=1.0, right=2.0, position=11;
  - edge=0, count=4, strobe at T+1.
- Frame values 5.0, 1.0, 1.0:
  - position=first, left=0, right=1.0, edge=1.
- Frame values 1.0, 2.0, 4.0, with the last sample coincident with frame_end:
  - peak 4.0, right=0, edge=1.
- Ties and sign:
  - 2.0, 2.0, 2.0 gives the first position with right=2.0;
  - the sample 0xC0000000 (-2.0) never wins over 0x3F800000.
- Control boundaries:
  - frame_end with no samples gives empty=1, count=0, value=0;
  - a frame_end followed by a sample at T+1 puts that sample in the next frame only;
  - rst mid-frame gives no strobe, and all outputs are 0.
- With PEAK_THRESHOLD_EN and threshold 3.0:
  - peak 3.0 gives found=0;
  - peak 3.5 gives found=1.
